// File: rtl/pulse_status_tx_pkg.sv
// Shared definitions for the host-link reply path: transmitter state encoding,
// frame geometry and the modulo-256 checksum also used by the command receiver.
package pulse_status_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_FINISH
   } tx_state_t;

   localparam int FRAME_LEN = 6;
   localparam int IDX_W     = 3;

   // Sum of the four payload bytes, wrapping at 8 bits.
   function automatic logic [7:0] checksum8(input logic [31:0] data);
      return data[7:0] + data[15:8] + data[23:16] + data[31:24];
   endfunction

endpackage

// File: rtl/pulse_status_tx.sv
// Reply-frame transmitter: latches a 32-bit value and a control tag on request and
// feeds a byte-wide UART with data[0..3], ctrl, checksum; all outputs are registered.
module pulse_status_tx
   import pulse_status_tx_pkg::*;
#(
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [7:0]  req_ctrl,
   input  logic [31:0] req_data,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic        tx_transmit,
   output logic [7:0]  tx_byte,
   input  logic        tx_busy
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   tx_state_t        state, state_next;
   logic [IDX_W-1:0] idx_q, idx_next;
   logic [CNT_W-1:0] cnt_q, cnt_next, cnt_inc;
   logic             abort_q, abort_next;
   logic             load;
   logic             strobe_next;
   logic [7:0]       byte_next;
   logic [7:0]       frame_sel;

   logic [31:0]      data_q;
   logic [7:0]       ctrl_q;
   logic [7:0]       csum_q;

   always_comb begin
      case (idx_q)
         3'd0:    frame_sel = data_q[7:0];
         3'd1:    frame_sel = data_q[15:8];
         3'd2:    frame_sel = data_q[23:16];
         3'd3:    frame_sel = data_q[31:24];
         3'd4:    frame_sel = ctrl_q;
         default: frame_sel = csum_q;
      endcase
   end

   assign cnt_inc = cnt_q + 1'b1;

   // NOTE: every signal driven here gets a default first, so no path leaves a
   // value unassigned and no latch can be inferred.
   always_comb begin
      state_next  = state;
      idx_next    = idx_q;
      cnt_next    = cnt_q;
      abort_next  = abort_q;
      load        = 1'b0;
      strobe_next = 1'b0;
      byte_next   = tx_byte;

      case (state)
         ST_IDLE: begin
            if (req) begin
               load       = 1'b1;
               idx_next   = '0;
               abort_next = 1'b0;
               // Byte 0 comes straight from the request so the first strobe
               // lands one cycle after acceptance.
               strobe_next = 1'b1;
               byte_next   = req_data[7:0];
               state_next  = ST_SEND;
            end
         end

         ST_SEND: begin
            cnt_next = '0;
            if (tx_transmit) begin
               state_next = ST_WAIT_HI;
            end else begin
               strobe_next = 1'b1;
               byte_next   = frame_sel;
            end
         end

         ST_WAIT_HI: begin
            // A busy flag already high here is taken as the rise.
            if (tx_busy) begin
               state_next = ST_WAIT_LO;
            end else begin
               cnt_next = cnt_inc;
               if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                  abort_next = 1'b1;
                  state_next = ST_FINISH;
               end
            end
         end

         ST_WAIT_LO: begin
            if (!tx_busy) begin
               if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                  state_next = ST_FINISH;
               end else begin
                  idx_next   = idx_q + 1'b1;
                  state_next = ST_SEND;
               end
            end
         end

         // Both normal completion and an aborted frame pass through here so
         // that ready returns one cycle after the done/err pulse.
         ST_FINISH: state_next = ST_IDLE;

         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         ready       <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         tx_transmit <= 1'b0;
         tx_byte     <= 8'h00;
      end else begin
         state       <= state_next;
         idx_q       <= idx_next;
         cnt_q       <= cnt_next;
         abort_q     <= abort_next;
         ready       <= (state_next == ST_IDLE);
         done        <= (state_next == ST_FINISH) && !abort_next;
         err         <= (state_next == ST_FINISH) && abort_next;
         tx_transmit <= strobe_next;
         tx_byte     <= byte_next;
      end
   end

   // NOTE: the payload registers carry no reset; they are always reloaded on
   // acceptance before any byte is taken from them.
   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= req_data;
         ctrl_q <= req_ctrl;
         csum_q <= checksum8(req_data);
      end
   end

endmodule
